wvb_circular_storage: RTL and testbench
=======================================

// Module: wvb_circular_storage
// PURPOSE
//  Next-generation waveform buffer storage: a circular sample RAM with internally managed write pointer,
//  free-space accounting and a show-ahead header FIFO carrying {hdr, start_addr, stop_addr}.
//  Sits between the trigger/waveform-capture logic (write side) and the readout engine (read side).
//  Whole-event drop on insufficient space; exact occupancy counts, including full.
// PARAMETERS
//  P_DATA_WIDTH         22   sample word width; bit 0 is replaced by the end-of-event flag
//  P_ADR_WIDTH          12   sample RAM address width; depth = 2**P_ADR_WIDTH
//  P_HDR_WIDTH          80   user header width
//  P_HDR_DEPTH_LOG2      7   header FIFO depth = 2**P_HDR_DEPTH_LOG2
//  P_MAX_EVT_LEN       256   max samples per event; also the admission space threshold
//  P_N_WVF_IN_BUF_WIDTH 16   n_wvf_in_buf width; must be >= P_HDR_DEPTH_LOG2+1
// PORTS
//  clk            in   1     system clock
//  rst            in   1     asynchronous reset, active-high
//  wvb_wrreq      in   1     sample valid
//  wvb_data_in    in   P_DATA_WIDTH   sample
//  eoe_in         in   1     last sample of event (qualified by wvb_wrreq)
//  hdr_data_in    in   P_HDR_WIDTH    header, sampled on the eoe_in beat
//  wvb_rd_addr    in   P_ADR_WIDTH    readout RAM address
//  wvb_data_out   out  P_DATA_WIDTH   RAM data, 1 cycle after wvb_rd_addr
//  hdr_rdreq      in   1     pop head header; releases its samples
//  hdr_data_out   out  P_HDR_WIDTH    head header (show-ahead)
//  hdr_start_addr out  P_ADR_WIDTH    head event first-sample address
//  hdr_stop_addr  out  P_ADR_WIDTH    head event last-sample address
//  hdr_empty      out  1     no complete event stored
//  hdr_full       out  1     header FIFO holds 2**P_HDR_DEPTH_LOG2 entries
//  n_wvf_in_buf   out  P_N_WVF_IN_BUF_WIDTH  header count, 0..2**P_HDR_DEPTH_LOG2 exact
//  used_words     out  P_ADR_WIDTH+1  occupied RAM words, 0..2**P_ADR_WIDTH exact
//  evt_drop       out  1     1-cycle pulse when an event is rejected at its first sample
//  evt_trunc      out  1     1-cycle pulse when an event is force-terminated at P_MAX_EVT_LEN
// BEHAVIOUR
//  Reset: wr_ptr=0, used_words=0, FIFO empty (hdr_empty=1, hdr_full=0, n_wvf_in_buf=0), FSM IDLE,
//   evt_drop=evt_trunc=0, hdr_* outputs 0. Reset mid-event discards the partial event; RAM contents undefined.
//  FSM IDLE/WRITE/DISCARD.
//   IDLE, wvb_wrreq: admit iff (2**P_ADR_WIDTH - used_words) >= P_MAX_EVT_LEN and !hdr_full;
//    admit -> write at wr_ptr, latch start_addr=wr_ptr, len=1, go WRITE (stay IDLE if eoe_in on same beat);
//    reject -> evt_drop pulse next cycle, go DISCARD (stay IDLE if eoe_in on same beat).
//   WRITE: each wvb_wrreq writes {data[W-1:1], eoe} at wr_ptr, wr_ptr+1 mod depth, len+1.
//    When len reaches P_MAX_EVT_LEN without eoe_in: stored bit0 forced 1, evt_trunc pulse, go DISCARD.
//   DISCARD: samples ignored until wvb_wrreq&eoe_in -> IDLE.
//  Event completion (eoe stored or forced): push {hdr_data_in, start_addr, stop_addr=addr of that sample};
//   visible on hdr_* next cycle; forced-eoe case latches hdr_data_in = 0.
//  used_words increments per written sample; on hdr_rdreq&!hdr_empty decrements by
//   (stop-start+1) mod depth, with 0 meaning full depth. Same-cycle write and release net correctly.
//  hdr_rdreq on empty ignored. Simultaneous push and pop: count unchanged.
//  Wrap-around: addresses modulo depth; stop_addr < start_addr is legal.
//  Readout reads RAM before popping; the RAM is simple dual port, 1-cycle read, no read/write collision
//   possible on released space.
// CONFIGURATION
//  WVB_STORAGE_DROP_CNT_EN defined: adds output drop_cnt[15:0] (saturating count of evt_drop+evt_trunc
//   events, reset 0) and input drop_cnt_clr (synchronous clear, priority over increment).
//  Undefined: ports absent, no counter logic.
// STRUCTURE
//  Package wvb_storage_pkg: FSM state enum (IDLE/WRITE/DISCARD), header-entry packing widths/offsets.
//  Sub-module wvb_hdr_fifo: parametrised show-ahead sync FIFO (width, depth log2) with exact count
//   and full/empty; RAM is inferred inline.
// TESTING (P_ADR_WIDTH=6, P_MAX_EVT_LEN=16, P_HDR_DEPTH_LOG2=2)
//  1. One 10-sample event, hdr 0xABC -> hdr_start=0, stop=9, used_words=10, n_wvf=1; pop -> used_words=0, hdr_empty=1.
//  2. Four 16-sample events, no pops -> used_words=64, hdr_full=1, n_wvf=4; 5th event -> evt_drop, count stays 4.
//  3. Pre-fill wr_ptr=58, 10-sample event -> start=58, stop=3 (wrap); pop releases exactly 10 words.
//  4. 20 samples without eoe -> 16 stored, bit0 of word 15 = 1, evt_trunc, samples 17-20 ignored.
//  5. Push completion and pop on same cycle at n_wvf=2 -> n_wvf stays 2, used_words = old + 1 - popped len.
//  6. rst asserted mid-event at sample 5 -> all outputs at reset values; next event starts at addr 0.

Source files
------------

// File: rtl/wvb_storage_pkg.sv
// Shared types and header-entry layout helpers for the waveform buffer storage.
// Header entry layout (MSB..LSB): {hdr, start_addr, stop_addr}.
package wvb_storage_pkg;

  // Write-side event admission FSM
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_DISCARD = 2'd2
  } wvb_state_t;

  localparam int unsigned ENTRY_STOP_OFS = 0;

  function automatic int unsigned hdr_entry_width(int unsigned hdr_w, int unsigned adr_w);
    return hdr_w + 2 * adr_w;
  endfunction

  function automatic int unsigned entry_start_ofs(int unsigned adr_w);
    return adr_w;
  endfunction

  function automatic int unsigned entry_hdr_ofs(int unsigned adr_w);
    return 2 * adr_w;
  endfunction

endpackage

// File: rtl/wvb_hdr_fifo.sv
// Show-ahead synchronous FIFO with exact occupancy count.
// Ports: wr_en/wr_data push; rd_en pops the head (ignored when empty);
//   rd_data is the registered head entry (0 while empty); empty/full/count registered.
module wvb_hdr_fifo #(
  parameter int unsigned P_WIDTH      = 104,
  parameter int unsigned P_DEPTH_LOG2 = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [P_WIDTH-1:0]      wr_data,
  input  logic                    rd_en,
  output logic [P_WIDTH-1:0]      rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [P_DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 2 ** P_DEPTH_LOG2;
  localparam int unsigned CW    = P_DEPTH_LOG2 + 1;

  logic [P_WIDTH-1:0]      mem [DEPTH];
  logic [P_DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]           cnt_nxt;
  logic [P_WIDTH-1:0]      head_nxt;
  logic                    push, pop;

  // Next head: bypass the entry being written when it lands on the new read slot
  always_comb begin
    pop        = rd_en && !empty;
    push       = wr_en && (!full || pop);
    rd_ptr_nxt = pop ? rd_ptr + P_DEPTH_LOG2'(1) : rd_ptr;
    cnt_nxt    = count + CW'(push) - CW'(pop);
    head_nxt   = '0;
    if (cnt_nxt != '0) begin
      if (push && (wr_ptr == rd_ptr_nxt)) head_nxt = wr_data;
      else                                head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_DEPTH_LOG2'(1);
      rd_ptr  <= rd_ptr_nxt;
      count   <= cnt_nxt;
      rd_data <= head_nxt;
      empty   <= (cnt_nxt == '0);
      full    <= (cnt_nxt == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/wvb_circular_storage.sv
// Circular waveform sample RAM with internal write pointer, exact free-space
// accounting and a show-ahead header FIFO of {hdr, start_addr, stop_addr}.
// Write side: wvb_wrreq/wvb_data_in/eoe_in/hdr_data_in. Read side: wvb_rd_addr ->
//   wvb_data_out (1 cycle), hdr_* head of FIFO, hdr_rdreq pops and releases samples.
// Status: hdr_empty, hdr_full, n_wvf_in_buf, used_words, evt_drop, evt_trunc pulses.
// Optional WVB_STORAGE_DROP_CNT_EN: drop_cnt (saturating) and drop_cnt_clr.
module wvb_circular_storage
  import wvb_storage_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH         = 22,
  parameter int unsigned P_ADR_WIDTH          = 12,
  parameter int unsigned P_HDR_WIDTH          = 80,
  parameter int unsigned P_HDR_DEPTH_LOG2     = 7,
  parameter int unsigned P_MAX_EVT_LEN        = 256,
  parameter int unsigned P_N_WVF_IN_BUF_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wvb_wrreq,
  input  logic [P_DATA_WIDTH-1:0]         wvb_data_in,
  input  logic                            eoe_in,
  input  logic [P_HDR_WIDTH-1:0]          hdr_data_in,
  input  logic [P_ADR_WIDTH-1:0]          wvb_rd_addr,
  output logic [P_DATA_WIDTH-1:0]         wvb_data_out,
  input  logic                            hdr_rdreq,
  output logic [P_HDR_WIDTH-1:0]          hdr_data_out,
  output logic [P_ADR_WIDTH-1:0]          hdr_start_addr,
  output logic [P_ADR_WIDTH-1:0]          hdr_stop_addr,
  output logic                            hdr_empty,
  output logic                            hdr_full,
  output logic [P_N_WVF_IN_BUF_WIDTH-1:0] n_wvf_in_buf,
  output logic [P_ADR_WIDTH:0]            used_words,
  output logic                            evt_drop,
  output logic                            evt_trunc
`ifdef WVB_STORAGE_DROP_CNT_EN
  ,
  output logic [15:0]                     drop_cnt,
  input  logic                            drop_cnt_clr
`endif
);

  localparam int unsigned DEPTH     = 2 ** P_ADR_WIDTH;
  localparam int unsigned UW        = P_ADR_WIDTH + 1;
  localparam int unsigned LEN_W     = $clog2(P_MAX_EVT_LEN + 1);
  localparam int unsigned ENTRY_W   = hdr_entry_width(P_HDR_WIDTH, P_ADR_WIDTH);
  localparam int unsigned START_OFS = entry_start_ofs(P_ADR_WIDTH);
  localparam int unsigned HDR_OFS   = entry_hdr_ofs(P_ADR_WIDTH);

  wvb_state_t              state_q, state_d;
  logic [P_ADR_WIDTH-1:0]  wr_ptr_q, start_q, start_c, span_c;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [UW-1:0]           rel_c, used_d;
  logic                    admit_c, wr_en_c, force_c, push_c, drop_c, pop_c;
  logic [P_DATA_WIDTH-1:0] wr_word_c;
  logic [ENTRY_W-1:0]      entry_c, head;
  logic [P_HDR_DEPTH_LOG2:0] fifo_cnt;
  logic [P_DATA_WIDTH-1:0] ram [DEPTH];
  logic                    unused_data_bit0;

  assign unused_data_bit0 = wvb_data_in[0];

  // Admission / event-length FSM (next state and write controls)
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    start_c = start_q;
    wr_en_c = 1'b0;
    force_c = 1'b0;
    push_c  = 1'b0;
    drop_c  = 1'b0;
    admit_c = (used_words <= UW'(DEPTH - P_MAX_EVT_LEN)) && !hdr_full;
    case (state_q)
      ST_IDLE: begin
        if (wvb_wrreq) begin
          if (admit_c) begin
            wr_en_c = 1'b1;
            start_c = wr_ptr_q;
            len_d   = LEN_W'(1);
            if (eoe_in) push_c  = 1'b1;
            else        state_d = ST_WRITE;
          end else begin
            drop_c = 1'b1;
            if (!eoe_in) state_d = ST_DISCARD;
          end
        end
      end
      ST_WRITE: begin
        if (wvb_wrreq) begin
          wr_en_c = 1'b1;
          len_d   = len_q + LEN_W'(1);
          if (eoe_in) begin
            push_c  = 1'b1;
            state_d = ST_IDLE;
          end else if (len_q == LEN_W'(P_MAX_EVT_LEN - 1)) begin
            force_c = 1'b1;
            push_c  = 1'b1;
            state_d = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (wvb_wrreq && eoe_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stored word, header entry and release accounting
  always_comb begin
    wr_word_c = {wvb_data_in[P_DATA_WIDTH-1:1], eoe_in | force_c};
    entry_c   = '0;
    entry_c[HDR_OFS +: P_HDR_WIDTH]        = force_c ? '0 : hdr_data_in;
    entry_c[START_OFS +: P_ADR_WIDTH]      = start_c;
    entry_c[ENTRY_STOP_OFS +: P_ADR_WIDTH] = wr_ptr_q;
    pop_c  = hdr_rdreq && !hdr_empty;
    // A zero span means the event occupies the whole RAM
    span_c = hdr_stop_addr - hdr_start_addr + P_ADR_WIDTH'(1);
    rel_c  = (span_c == '0) ? UW'(DEPTH) : UW'(span_c);
    used_d = used_words + UW'(wr_en_c) - (pop_c ? rel_c : UW'(0));
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) ram[wr_ptr_q] <= wr_word_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      start_q      <= '0;
      len_q        <= '0;
      used_words   <= '0;
      evt_drop     <= 1'b0;
      evt_trunc    <= 1'b0;
      wvb_data_out <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_c;
      len_q        <= len_d;
      used_words   <= used_d;
      evt_drop     <= drop_c;
      evt_trunc    <= force_c;
      wvb_data_out <= ram[wvb_rd_addr];
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + P_ADR_WIDTH'(1);
    end
  end

  wvb_hdr_fifo #(
    .P_WIDTH      (ENTRY_W),
    .P_DEPTH_LOG2 (P_HDR_DEPTH_LOG2)
  ) u_hdr_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_c),
    .wr_data (entry_c),
    .rd_en   (hdr_rdreq),
    .rd_data (head),
    .empty   (hdr_empty),
    .full    (hdr_full),
    .count   (fifo_cnt)
  );

  assign hdr_data_out   = head[HDR_OFS +: P_HDR_WIDTH];
  assign hdr_start_addr = head[START_OFS +: P_ADR_WIDTH];
  assign hdr_stop_addr  = head[ENTRY_STOP_OFS +: P_ADR_WIDTH];
  assign n_wvf_in_buf   = P_N_WVF_IN_BUF_WIDTH'(fifo_cnt);

`ifdef WVB_STORAGE_DROP_CNT_EN
  // Saturating count of rejected and truncated events
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          drop_cnt <= '0;
    else if (drop_cnt_clr)                            drop_cnt <= '0;
    else if ((evt_drop || evt_trunc) && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_wvb_circular_storage.sv
// Directed self-checking bench for wvb_circular_storage (64-word RAM, 16-sample
// max event, 4-entry header FIFO).
module tb_wvb_circular_storage;

  localparam int unsigned DW = 22;
  localparam int unsigned AW = 6;
  localparam int unsigned HW = 80;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wvb_wrreq = 1'b0;
  logic [DW-1:0] wvb_data_in = '0;
  logic          eoe_in = 1'b0;
  logic [HW-1:0] hdr_data_in = '0;
  logic [AW-1:0] wvb_rd_addr = '0;
  logic [DW-1:0] wvb_data_out;
  logic          hdr_rdreq = 1'b0;
  logic [HW-1:0] hdr_data_out;
  logic [AW-1:0] hdr_start_addr, hdr_stop_addr;
  logic          hdr_empty, hdr_full;
  logic [15:0]   n_wvf_in_buf;
  logic [AW:0]   used_words;
  logic          evt_drop, evt_trunc;
`ifdef WVB_STORAGE_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  wvb_circular_storage #(
    .P_DATA_WIDTH(DW), .P_ADR_WIDTH(AW), .P_HDR_WIDTH(HW), .P_HDR_DEPTH_LOG2(2),
    .P_MAX_EVT_LEN(16), .P_N_WVF_IN_BUF_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .wvb_wrreq(wvb_wrreq), .wvb_data_in(wvb_data_in),
    .eoe_in(eoe_in), .hdr_data_in(hdr_data_in), .wvb_rd_addr(wvb_rd_addr),
    .wvb_data_out(wvb_data_out), .hdr_rdreq(hdr_rdreq), .hdr_data_out(hdr_data_out),
    .hdr_start_addr(hdr_start_addr), .hdr_stop_addr(hdr_stop_addr),
    .hdr_empty(hdr_empty), .hdr_full(hdr_full), .n_wvf_in_buf(n_wvf_in_buf),
    .used_words(used_words), .evt_drop(evt_drop), .evt_trunc(evt_trunc)
`ifdef WVB_STORAGE_DROP_CNT_EN
    , .drop_cnt(drop_cnt), .drop_cnt_clr(1'b0)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input sample always has bit0 set; the stored word must carry eoe there instead
  function automatic logic [DW-1:0] sample_in(int tag, int i);
    return DW'((tag << 8) | (i << 1) | 1);
  endfunction

  function automatic logic [DW-1:0] exp_word(int tag, int i, bit eoe);
    return DW'((tag << 8) | (i << 1)) | DW'(eoe);
  endfunction

  task automatic send_sample(input int tag, input int i, input bit eoe, input logic [HW-1:0] hdr);
    wvb_wrreq   = 1'b1;
    wvb_data_in = sample_in(tag, i);
    eoe_in      = eoe;
    hdr_data_in = hdr;
    tick();
    wvb_wrreq = 1'b0;
    eoe_in    = 1'b0;
  endtask

  task automatic send_event(input int tag, input int n, input logic [HW-1:0] hdr);
    for (int i = 0; i < n; i++) send_sample(tag, i, (i == n - 1), hdr);
  endtask

  task automatic pop();
    hdr_rdreq = 1'b1;
    tick();
    hdr_rdreq = 1'b0;
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d);
    wvb_rd_addr = a;
    tick();
    d = wvb_data_out;
  endtask

  logic [DW-1:0] rd;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_used", used_words, 0);
    chk("rst_empty", hdr_empty, 1);
    chk("rst_full", hdr_full, 0);
    chk("rst_nwvf", n_wvf_in_buf, 0);
    chk("rst_hdr", hdr_data_out, 0);
    chk("rst_start", hdr_start_addr, 0);
    chk("rst_stop", hdr_stop_addr, 0);
    chk("rst_drop", evt_drop, 0);
    chk("rst_trunc", evt_trunc, 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // 1: single 10-sample event
    send_event(1, 10, 80'hABC);
    chk("t1_start", hdr_start_addr, 0);
    chk("t1_stop", hdr_stop_addr, 9);
    chk("t1_used", used_words, 10);
    chk("t1_nwvf", n_wvf_in_buf, 1);
    chk("t1_hdr", hdr_data_out, 80'hABC);
    chk("t1_empty", hdr_empty, 0);
    read_word(6'd9, rd);
    chk("t1_word9", rd, exp_word(1, 9, 1));
    read_word(6'd3, rd);
    chk("t1_word3", rd, exp_word(1, 3, 0));
    pop();
    chk("t1_pop_used", used_words, 0);
    chk("t1_pop_empty", hdr_empty, 1);
    pop();
    chk("t1_emptypop_used", used_words, 0);
    chk("t1_emptypop_nwvf", n_wvf_in_buf, 0);

    // 2: four full-length events fill RAM and FIFO; fifth is dropped
    for (int e = 0; e < 4; e++) send_event(2 + e, 16, HW'(32'h200 + e));
    chk("t2_used", used_words, 64);
    chk("t2_full", hdr_full, 1);
    chk("t2_nwvf", n_wvf_in_buf, 4);
    chk("t2_start", hdr_start_addr, 10);
    chk("t2_stop", hdr_stop_addr, 25);
    send_sample(6, 0, 0, 80'h999);
    chk("t2_drop", evt_drop, 1);
    send_sample(6, 1, 0, 80'h999);
    chk("t2_drop_pulse", evt_drop, 0);
    send_sample(6, 2, 1, 80'h999);
    chk("t2_drop_nwvf", n_wvf_in_buf, 4);
    chk("t2_drop_used", used_words, 64);
    pop();
    chk("t2_pop1_used", used_words, 48);
    chk("t2_pop1_start", hdr_start_addr, 26);
    chk("t2_pop1_stop", hdr_stop_addr, 41);
    chk("t2_pop1_hdr", hdr_data_out, 80'h201);
    chk("t2_pop1_full", hdr_full, 0);
    repeat (3) pop();
    chk("t2_drain_used", used_words, 0);
    chk("t2_drain_empty", hdr_empty, 1);

    // 3: advance wr_ptr to 58, then a wrapping 10-sample event
    for (int e = 0; e < 3; e++) begin
      send_event(20, 16, 80'h1);
      pop();
    end
    chk("t3_prefill_used", used_words, 0);
    send_event(7, 10, 80'h777);
    chk("t3_start", hdr_start_addr, 58);
    chk("t3_stop", hdr_stop_addr, 3);
    chk("t3_used", used_words, 10);
    read_word(6'd63, rd);
    chk("t3_word63", rd, exp_word(7, 5, 0));
    read_word(6'd0, rd);
    chk("t3_word0", rd, exp_word(7, 6, 0));
    read_word(6'd3, rd);
    chk("t3_word3", rd, exp_word(7, 9, 1));
    pop();
    chk("t3_pop_used", used_words, 0);

    // 4: truncation at 16 samples, starting at address 4
    for (int i = 0; i < 20; i++) begin
      send_sample(8, i, 0, 80'hDEAD);
      if (i == 15) begin
        chk("t4_trunc", evt_trunc, 1);
        chk("t4_nwvf", n_wvf_in_buf, 1);
        chk("t4_start", hdr_start_addr, 4);
        chk("t4_stop", hdr_stop_addr, 19);
        chk("t4_hdr_zero", hdr_data_out, 0);
        chk("t4_used", used_words, 16);
      end
      if (i == 16) chk("t4_trunc_pulse", evt_trunc, 0);
    end
    send_sample(8, 20, 1, 80'hDEAD);
    chk("t4_ignored_used", used_words, 16);
    chk("t4_ignored_nwvf", n_wvf_in_buf, 1);
    read_word(6'd19, rd);
    chk("t4_word19", rd, exp_word(8, 15, 1));
    read_word(6'd18, rd);
    chk("t4_word18", rd, exp_word(8, 14, 0));

    // 5: completion and pop in the same cycle at two stored events
    send_event(9, 5, 80'h55);
    chk("t5_pre_nwvf", n_wvf_in_buf, 2);
    chk("t5_pre_used", used_words, 21);
    for (int i = 0; i < 3; i++) send_sample(10, i, 0, 80'h66);
    chk("t5_mid_used", used_words, 24);
    hdr_rdreq = 1'b1;
    send_sample(10, 3, 1, 80'h66);
    hdr_rdreq = 1'b0;
    chk("t5_nwvf", n_wvf_in_buf, 2);
    chk("t5_used", used_words, 9);
    chk("t5_start", hdr_start_addr, 20);
    chk("t5_stop", hdr_stop_addr, 24);
    chk("t5_hdr", hdr_data_out, 80'h55);
    pop();
    chk("t5_pop1_used", used_words, 4);
    chk("t5_pop1_start", hdr_start_addr, 25);
    chk("t5_pop1_stop", hdr_stop_addr, 28);
    chk("t5_pop1_hdr", hdr_data_out, 80'h66);
    pop();
    chk("t5_pop2_used", used_words, 0);
    chk("t5_pop2_empty", hdr_empty, 1);

    // 6: reset in the middle of an event
    for (int i = 0; i < 5; i++) send_sample(11, i, 0, 80'h0);
    chk("t6_pre_used", used_words, 5);
    rst = 1'b1;
    #2;
    chk("t6_rst_used", used_words, 0);
    chk("t6_rst_nwvf", n_wvf_in_buf, 0);
    chk("t6_rst_empty", hdr_empty, 1);
    chk("t6_rst_full", hdr_full, 0);
    chk("t6_rst_hdr", hdr_data_out, 0);
    chk("t6_rst_start", hdr_start_addr, 0);
    chk("t6_rst_stop", hdr_stop_addr, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    send_event(12, 3, 80'h1234);
    chk("t6_start", hdr_start_addr, 0);
    chk("t6_stop", hdr_stop_addr, 2);
    chk("t6_used", used_words, 3);
    chk("t6_hdr", hdr_data_out, 80'h1234);
    read_word(6'd0, rd);
    chk("t6_word0", rd, exp_word(12, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
